// File: rtl/irq_priority_encoder_pkg.sv
// Shared constants and helpers for the 8-line interrupt priority encoder.
package irq_priority_encoder_pkg;

  localparam int IRQ_LINES = 8;
  localparam int CODE_W    = 3;

  // Index of the most significant set bit; 0 when the vector is empty.
  function automatic logic [CODE_W-1:0] highest_set_idx(input logic [IRQ_LINES-1:0] vec);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < IRQ_LINES; i++) begin
      if (vec[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_priority_encoder_sync_edge_detect.sv
// One request line: multi-flop synchronizer followed by a falling-edge detector.
module irq_priority_encoder_sync_edge_detect
  import irq_priority_encoder_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic din_n,
  output logic sync,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din_n};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // History resets inactive so a line held low through reset is not seen as an edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];
  assign fall = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/irq_priority_encoder.sv
// 74F148-style 8-to-3 priority encoder: latches active-low requests as pending
// and presents the highest-priority index through a valid/ready handshake.
module irq_priority_encoder
  import irq_priority_encoder_pkg::*;
#(
  parameter int                   SYNC_STAGES = 2,
  parameter logic [IRQ_LINES-1:0] EDGE_MASK   = 8'hFF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [IRQ_LINES-1:0] req_n,
  input  logic                 ei_n,
  input  logic                 irq_ready,
  output logic                 irq_valid,
  output logic [CODE_W-1:0]    irq_code,
  output logic                 gs_n,
  output logic [IRQ_LINES-1:0] pending
);

  logic [IRQ_LINES-1:0] sync_lvl;
  logic [IRQ_LINES-1:0] fall;

  generate
    for (genvar gi = 0; gi < IRQ_LINES; gi++) begin : g_line
      irq_priority_encoder_sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
      ) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .din_n(req_n[gi]),
        .sync (sync_lvl[gi]),
        .fall (fall[gi])
      );
    end
  endgenerate

  logic [IRQ_LINES-1:0] pending_q, pending_d;
  logic                 irq_valid_q, irq_valid_d;
  logic [CODE_W-1:0]    irq_code_q, irq_code_d;
  logic                 gs_n_q, gs_n_d;
  logic                 accept;
  logic                 load;
  logic [IRQ_LINES-1:0] accept_mask;
  logic [IRQ_LINES-1:0] candidate;

  always_comb begin
    accept      = irq_valid_q & irq_ready;
    accept_mask = '0;
    if (accept) accept_mask[irq_code_q] = 1'b1;

    // A new edge wins over a simultaneous accept; level bits just track the line.
    pending_d = (EDGE_MASK & (fall | (pending_q & ~accept_mask)))
              | (~EDGE_MASK & ~sync_lvl);
    gs_n_d    = ~|pending_d;

    candidate   = pending_q & ~(accept_mask & EDGE_MASK);
    load        = ~irq_valid_q | irq_ready;
    irq_valid_d = irq_valid_q;
    irq_code_d  = irq_code_q;
    if (load) begin
      irq_valid_d = ~ei_n & (|candidate);
      if (irq_valid_d) irq_code_d = highest_set_idx(candidate);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending_q   <= '0;
      irq_valid_q <= 1'b0;
      irq_code_q  <= '0;
      gs_n_q      <= 1'b1;
    end else begin
      pending_q   <= pending_d;
      irq_valid_q <= irq_valid_d;
      irq_code_q  <= irq_code_d;
      gs_n_q      <= gs_n_d;
    end
  end

  assign pending   = pending_q;
  assign irq_valid = irq_valid_q;
  assign irq_code  = irq_code_q;
  assign gs_n      = gs_n_q;

endmodule
